// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the 4-digit multiplexed 7-segment scanner:
// state encoding, active-low segment constants and default tick counts.
package seg_scan_ctrl_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_t;

  localparam int DEF_SHOW_TICKS  = 4;
  localparam int DEF_BLANK_TICKS = 1;

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;

  // Active-low {g,f,e,d,c,b,a} patterns for BCD 0..9
  localparam logic [6:0] SEG_TABLE [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

endpackage

// File: rtl/seg_scan_ctrl_bcd7seg.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD codes show a dash.
module bcd7seg
  import seg_scan_ctrl_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (bcd <= 4'd9) seg = SEG_TABLE[bcd];
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Tick-paced 4-digit display scanner with blank guard time between digits and
// a frame buffer that only reloads at frame boundaries (req/ack handshake).
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int SHOW_TICKS  = DEF_SHOW_TICKS,
  parameter int BLANK_TICKS = DEF_BLANK_TICKS
) (
  input  logic        mclk,
  input  logic        reset,
  input  logic        tick,
  input  logic        en,
  input  logic        lzb,
  input  logic [15:0] digits,
  input  logic        upd_req,
  output logic        upd_ack,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        frame_done
);

  localparam logic [3:0] SHOW_LAST  = 4'(SHOW_TICKS);
  localparam logic [3:0] BLANK_LAST = 4'(BLANK_TICKS);

  scan_state_t state, state_n;
  logic [1:0]  idx, idx_n;
  logic [3:0]  tcnt, tcnt_n;
  logic [15:0] fbuf, fbuf_n;
  logic        armed, armed_n;
  logic        boundary;
  logic        load;
  logic        z1, z2, z3, dark;
  logic [3:0]  dig;
  logic [6:0]  dec_seg;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;

  bcd7seg u_dec (
    .bcd (dig),
    .seg (dec_seg)
  );

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    tcnt_n   = tcnt;
    boundary = 1'b0;
    if (!en) begin
      state_n = ST_BLANK;
      idx_n   = 2'd0;
      tcnt_n  = 4'd0;
    end else if (tick) begin
      tcnt_n = tcnt + 4'd1;
      case (state)
        ST_BLANK: begin
          if (tcnt_n == BLANK_LAST) begin
            state_n = ST_SHOW;
            tcnt_n  = 4'd0;
          end
        end
        ST_SHOW: begin
          if (tcnt_n == SHOW_LAST) begin
            state_n  = ST_BLANK;
            tcnt_n   = 4'd0;
            idx_n    = idx + 2'd1;
            boundary = (idx == 2'd3);
          end
        end
        default: ;
      endcase
    end
  end

  // The cycle in which frame_done is high is the only window for loading;
  // armed blocks a second load until upd_req has been seen low.
  always_comb begin
    load    = en && frame_done && upd_req && armed;
    fbuf_n  = load ? digits : fbuf;
    armed_n = armed;
    if (load)
      armed_n = 1'b0;
    else if (!upd_req)
      armed_n = 1'b1;
  end

  always_comb begin
    z3 = (fbuf_n[15:12] == 4'd0);
    z2 = z3 && (fbuf_n[11:8] == 4'd0);
    z1 = z2 && (fbuf_n[7:4] == 4'd0);
    dig  = fbuf_n[3:0];
    dark = 1'b0;
    case (idx_n)
      2'd0: dig = fbuf_n[3:0];
      2'd1: begin dig = fbuf_n[7:4];   dark = lzb && z1; end
      2'd2: begin dig = fbuf_n[11:8];  dark = lzb && z2; end
      2'd3: begin dig = fbuf_n[15:12]; dark = lzb && z3; end
      default: ;
    endcase
    an_n  = 4'hF;
    seg_n = SEG_OFF;
    if (state_n == ST_SHOW) begin
      an_n[idx_n] = 1'b0;
      seg_n       = dark ? SEG_OFF : dec_seg;
    end
  end

  // Outputs are registered from next-state values so they track the FSM
  // without a combinational path from the inputs.
  always_ff @(posedge mclk) begin
    if (reset) begin
      state      <= ST_BLANK;
      idx        <= 2'd0;
      tcnt       <= 4'd0;
      fbuf       <= 16'h0000;
      armed      <= 1'b1;
      an         <= 4'hF;
      seg        <= SEG_OFF;
      upd_ack    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      tcnt       <= tcnt_n;
      fbuf       <= fbuf_n;
      armed      <= armed_n;
      an         <= an_n;
      seg        <= seg_n;
      upd_ack    <= load;
      frame_done <= boundary;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: scan order, decoding, blanking, frame-boundary
// updates, enable and reset behaviour, using manual 10-cycle tick slots.
module tb_seg_scan_ctrl;

  logic        mclk = 1'b0;
  logic        reset, tick, en, lzb, upd_req;
  logic [15:0] digits;
  logic        upd_ack, frame_done;
  logic [3:0]  an;
  logic [6:0]  seg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [27:0] segs;
  logic [15:0] ans;
  int          lit, fdc, ackc;
  bit          fde, ackn;

  localparam logic [15:0] WALK_AN = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

  seg_scan_ctrl dut (
    .mclk       (mclk),
    .reset      (reset),
    .tick       (tick),
    .en         (en),
    .lzb        (lzb),
    .digits     (digits),
    .upd_req    (upd_req),
    .upd_ack    (upd_ack),
    .an         (an),
    .seg        (seg),
    .frame_done (frame_done)
  );

  always #5 mclk = ~mclk;

  // One full frame from BLANK idx 0: 20 tick slots of 10 cycles each.
  task automatic run_frame(input bit drop_on_ack, output logic [27:0] s_o,
                           output logic [15:0] a_o, output int lit_o,
                           output int fd_o, output int ack_o,
                           output bit fde_o, output bit ackn_o);
    bit prev_fd;
    s_o = '0; a_o = '0; lit_o = 0; fd_o = 0; ack_o = 0;
    fde_o = 0; ackn_o = 0; prev_fd = 0;
    for (int s = 0; s < 20; s++) begin
      tick = 1'b1;
      for (int c = 0; c < 10; c++) begin
        @(negedge mclk);
        tick = 1'b0;
        if (an !== 4'hF) lit_o++;
        if (c == 0 && (s % 5) == 0) begin
          s_o[(s/5)*7 +: 7] = seg;
          a_o[(s/5)*4 +: 4] = an;
        end
        if (frame_done) fd_o++;
        if (c == 0 && s == 19) fde_o = frame_done;
        if (upd_ack) begin
          ack_o++;
          if (prev_fd) ackn_o = 1'b1;
          if (drop_on_ack) upd_req = 1'b0;
        end
        prev_fd = frame_done;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; tick = 1'b1; upd_req = 1'b1; digits = 16'h1234;
    repeat (3) @(negedge mclk);
    n_checks++; if (an !== 4'hF) begin n_fail++; $display("FAIL reset_an act=%b exp=1111", an); end
    n_checks++; if (seg !== 7'h7F) begin n_fail++; $display("FAIL reset_seg act=%h exp=7f", seg); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_fd act=%b exp=0", frame_done); end
    n_checks++; if (upd_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack act=%b exp=0", upd_ack); end
    reset = 1'b0; tick = 1'b0;
  endtask

  task automatic test_first_update();
    run_frame(1'b1, segs, ans, lit, fdc, ackc, fde, ackn);
    n_checks++; if (segs !== {7'h40, 7'h40, 7'h40, 7'h40}) begin n_fail++; $display("FAIL first_seg act=%h exp=%h", segs, {7'h40, 7'h40, 7'h40, 7'h40}); end
    n_checks++; if (ans !== WALK_AN) begin n_fail++; $display("FAIL first_an act=%h exp=%h", ans, WALK_AN); end
    n_checks++; if (lit !== 160) begin n_fail++; $display("FAIL first_lit act=%0d exp=160", lit); end
    n_checks++; if (fdc !== 1 || fde !== 1'b1) begin n_fail++; $display("FAIL first_fd cnt=%0d end=%b exp 1/1", fdc, fde); end
    n_checks++; if (ackc !== 1 || ackn !== 1'b1) begin n_fail++; $display("FAIL first_ack cnt=%0d after_fd=%b exp 1/1", ackc, ackn); end
  endtask

  task automatic test_scan_1234();
    run_frame(1'b1, segs, ans, lit, fdc, ackc, fde, ackn);
    n_checks++; if (segs !== {7'h79, 7'h24, 7'h30, 7'h19}) begin n_fail++; $display("FAIL s1234_seg act=%h exp=%h", segs, {7'h79, 7'h24, 7'h30, 7'h19}); end
    n_checks++; if (ans !== WALK_AN) begin n_fail++; $display("FAIL s1234_an act=%h exp=%h", ans, WALK_AN); end
    n_checks++; if (lit !== 160) begin n_fail++; $display("FAIL s1234_lit act=%0d exp=160", lit); end
    n_checks++; if (fdc !== 1 || fde !== 1'b1) begin n_fail++; $display("FAIL s1234_fd cnt=%0d end=%b exp 1/1", fdc, fde); end
    n_checks++; if (ackc !== 0) begin n_fail++; $display("FAIL s1234_ack act=%0d exp=0", ackc); end
  endtask

  task automatic test_mid_frame_update();
    digits = 16'h0056; upd_req = 1'b1;
    run_frame(1'b1, segs, ans, lit, fdc, ackc, fde, ackn);
    n_checks++; if (segs !== {7'h79, 7'h24, 7'h30, 7'h19}) begin n_fail++; $display("FAIL mid_old_seg act=%h exp=%h", segs, {7'h79, 7'h24, 7'h30, 7'h19}); end
    n_checks++; if (ackc !== 1 || ackn !== 1'b1) begin n_fail++; $display("FAIL mid_ack cnt=%0d after_fd=%b exp 1/1", ackc, ackn); end
    run_frame(1'b1, segs, ans, lit, fdc, ackc, fde, ackn);
    n_checks++; if (segs !== {7'h40, 7'h40, 7'h12, 7'h02}) begin n_fail++; $display("FAIL mid_new_seg act=%h exp=%h", segs, {7'h40, 7'h40, 7'h12, 7'h02}); end
    n_checks++; if (ackc !== 0) begin n_fail++; $display("FAIL mid_new_ack act=%0d exp=0", ackc); end
  endtask

  task automatic test_lzb();
    lzb = 1'b1; digits = 16'h0007; upd_req = 1'b1;
    run_frame(1'b1, segs, ans, lit, fdc, ackc, fde, ackn);
    n_checks++; if (segs !== {7'h7F, 7'h7F, 7'h12, 7'h02}) begin n_fail++; $display("FAIL lzb56_seg act=%h exp=%h", segs, {7'h7F, 7'h7F, 7'h12, 7'h02}); end
    n_checks++; if (ans !== WALK_AN || lit !== 160) begin n_fail++; $display("FAIL lzb56_an act=%h lit=%0d exp=%h/160", ans, lit, WALK_AN); end
    digits = 16'h0000; upd_req = 1'b1;
    run_frame(1'b1, segs, ans, lit, fdc, ackc, fde, ackn);
    n_checks++; if (segs !== {7'h7F, 7'h7F, 7'h7F, 7'h78}) begin n_fail++; $display("FAIL lzb7_seg act=%h exp=%h", segs, {7'h7F, 7'h7F, 7'h7F, 7'h78}); end
    digits = 16'hFA09; upd_req = 1'b1;
    run_frame(1'b0, segs, ans, lit, fdc, ackc, fde, ackn);
    n_checks++; if (segs !== {7'h7F, 7'h7F, 7'h7F, 7'h40}) begin n_fail++; $display("FAIL lzb0_seg act=%h exp=%h", segs, {7'h7F, 7'h7F, 7'h7F, 7'h40}); end
    n_checks++; if (ackc !== 1) begin n_fail++; $display("FAIL lzb0_ack act=%0d exp=1", ackc); end
  endtask

  task automatic test_dash_and_hold();
    lzb = 1'b0; digits = 16'h1111;
    run_frame(1'b0, segs, ans, lit, fdc, ackc, fde, ackn);
    n_checks++; if (segs !== {7'h3F, 7'h3F, 7'h40, 7'h10}) begin n_fail++; $display("FAIL dash_seg act=%h exp=%h", segs, {7'h3F, 7'h3F, 7'h40, 7'h10}); end
    n_checks++; if (ackc !== 0) begin n_fail++; $display("FAIL held_req_ack act=%0d exp=0", ackc); end
  endtask

  task automatic test_back_to_back();
    upd_req = 1'b0;
    @(negedge mclk);
    upd_req = 1'b1;
    run_frame(1'b1, segs, ans, lit, fdc, ackc, fde, ackn);
    n_checks++; if (segs !== {7'h3F, 7'h3F, 7'h40, 7'h10}) begin n_fail++; $display("FAIL b2b_seg act=%h exp=%h", segs, {7'h3F, 7'h3F, 7'h40, 7'h10}); end
    n_checks++; if (ackc !== 1 || ackn !== 1'b1) begin n_fail++; $display("FAIL b2b_ack cnt=%0d after_fd=%b exp 1/1", ackc, ackn); end
  endtask

  task automatic test_en_drop();
    int fd_seen, ack_seen, lit_seen;
    fd_seen = 0; ack_seen = 0; lit_seen = 0;
    for (int s = 0; s < 11; s++) begin
      tick = 1'b1;
      @(negedge mclk);
      tick = 1'b0;
      repeat (9) @(negedge mclk);
    end
    n_checks++; if (an !== 4'b1011 || seg !== 7'h79) begin n_fail++; $display("FAIL en_pre an=%b seg=%h exp 1011/79", an, seg); end
    en = 1'b0;
    @(negedge mclk);
    n_checks++; if (an !== 4'hF || seg !== 7'h7F) begin n_fail++; $display("FAIL en_off an=%b seg=%h exp 1111/7f", an, seg); end
    digits = 16'h2222; upd_req = 1'b1;
    for (int s = 0; s < 25; s++) begin
      tick = 1'b1;
      for (int c = 0; c < 10; c++) begin
        @(negedge mclk);
        tick = 1'b0;
        if (frame_done) fd_seen++;
        if (upd_ack) ack_seen++;
        if (an !== 4'hF) lit_seen++;
      end
    end
    n_checks++; if (fd_seen !== 0 || ack_seen !== 0 || lit_seen !== 0) begin n_fail++; $display("FAIL en_dark fd=%0d ack=%0d lit=%0d exp 0/0/0", fd_seen, ack_seen, lit_seen); end
    en = 1'b1;
    repeat (3) @(negedge mclk);
    n_checks++; if (an !== 4'hF) begin n_fail++; $display("FAIL en_guard an=%b exp=1111", an); end
    tick = 1'b1;
    @(negedge mclk);
    tick = 1'b0;
    n_checks++; if (an !== 4'b1110 || seg !== 7'h79) begin n_fail++; $display("FAIL en_restart an=%b seg=%h exp 1110/79", an, seg); end
    repeat (9) @(negedge mclk);
  endtask

  task automatic test_reset_pending();
    for (int s = 0; s < 2; s++) begin
      tick = 1'b1;
      @(negedge mclk);
      tick = 1'b0;
      repeat (9) @(negedge mclk);
    end
    reset = 1'b1; tick = 1'b1;
    repeat (2) @(negedge mclk);
    n_checks++; if (an !== 4'hF || seg !== 7'h7F || upd_ack !== 1'b0 || frame_done !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid an=%b seg=%h ack=%b fd=%b exp 1111/7f/0/0", an, seg, upd_ack, frame_done);
    end
    reset = 1'b0; tick = 1'b0;
    run_frame(1'b1, segs, ans, lit, fdc, ackc, fde, ackn);
    n_checks++; if (segs !== {7'h40, 7'h40, 7'h40, 7'h40}) begin n_fail++; $display("FAIL rst_frame_seg act=%h exp=%h", segs, {7'h40, 7'h40, 7'h40, 7'h40}); end
    n_checks++; if (ackc !== 1 || ackn !== 1'b1 || fde !== 1'b1) begin n_fail++; $display("FAIL rst_ack cnt=%0d after_fd=%b fd_end=%b exp 1/1/1", ackc, ackn, fde); end
    run_frame(1'b1, segs, ans, lit, fdc, ackc, fde, ackn);
    n_checks++; if (segs !== {7'h24, 7'h24, 7'h24, 7'h24}) begin n_fail++; $display("FAIL rst_new_seg act=%h exp=%h", segs, {7'h24, 7'h24, 7'h24, 7'h24}); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; tick = 1'b0; en = 1'b0; lzb = 1'b0; upd_req = 1'b0; digits = 16'h0000;
    test_reset();
    test_first_update();
    test_scan_1234();
    test_mid_frame_update();
    test_lzb();
    test_dash_and_hold();
    test_back_to_back();
    test_en_drop();
    test_reset_pending();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
